bram_fifo: RTL and testbench
============================

BRAM_FIFO -- requirements
Module: bram_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter LOG2_DEPTH, default 5, log2 of BRAM entries; usable capacity is CAP = 2**LOG2_DEPTH - 1.
REQ-003 SHALL have parameter ALMOSTFULL_MARGIN, default 4, free-entry margin below CAP at which almostfull asserts.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port we, input, 1, write request.
REQ-007 SHALL have port wdata, input, WIDTH, write data.
REQ-008 SHALL have port re, input, 1, read request.
REQ-009 SHALL have port rdata, output, WIDTH, read data.
REQ-010 SHALL have port rvalid, output, 1, rdata valid this cycle.
REQ-011 SHALL have port almostfull, output, 1, occupancy at or above the threshold.
REQ-012 SHALL have port empty, output, 1, no entries stored.
REQ-013 SHALL have port count, output, LOG2_DEPTH, stored entries.
REQ-014 SHALL expose exactly the fifo_source side of fifobram_interface, so fifo_write and fifo_read users connect directly.

Function
REQ-015 SHALL accept a write when we=1 and count<CAP: store wdata at wptr, then wptr+1 modulo 2**LOG2_DEPTH.
REQ-016 SHALL drop a write when we=1 and count==CAP; no state change, no error reported unless REQ-031 is compiled in.
REQ-017 SHALL accept a read when re=1 and empty=0: BRAM read at rptr, then rptr+1 modulo 2**LOG2_DEPTH.
REQ-018 SHALL drive rvalid=1 and rdata=the entry exactly one cycle after an accepted read; rvalid=0 otherwise.
REQ-019 SHALL ignore re=1 while empty=1: rvalid=0 next cycle, rptr and count unchanged.
REQ-020 SHALL hold rdata at its last value while rvalid=0.
REQ-021 SHALL, on a simultaneous accepted write and read, perform both with count unchanged.
REQ-022 SHALL treat the empty case with we=1 and re=1 as write-only; the read is ignored, no bypass.
REQ-023 SHALL register count, empty and almostfull so they reflect all accepted operations of the previous cycle.
REQ-024 SHALL make a word written in cycle N readable from cycle N+1 (empty=0 in N+1); a read in N+1 returns it in N+2.
REQ-025 SHALL assert almostfull iff count >= CAP - ALMOSTFULL_MARGIN.
REQ-026 SHALL produce read-after-write-pointer wrap data identically to non-wrapped data.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, set wptr=0, rptr=0, count=0, empty=1, almostfull=0, rvalid=0 and rdata=0.
REQ-028 SHALL ignore we and re in any cycle where reset=1.
REQ-029 SHALL discard stored contents and any in-flight read on reset mid-operation; rvalid=0 the cycle after reset.
REQ-030 SHALL not require BRAM contents to be cleared.

Configuration
REQ-031 SHALL, with BRAM_FIFO_ERROR_FLAGS_EN defined, add outputs overflow (1) and underflow (1), sticky until reset, set the cycle after a dropped write (REQ-016) or ignored read (REQ-019); without the macro, neither port exists and drops are silent.

Structure
REQ-032 SHALL take the fifobram_interface definition and LOG2_* constants from the shared pipearch_common header; no new typedefs are needed.
REQ-033 SHALL isolate storage in one sub-module, simple_dual_port_bram (1 write port, 1 registered read port, 1-cycle latency); pointers, count and flags stay in bram_fifo.

Verification
REQ-034 SHALL test: after reset, write 0xA5 in cycle 0, assert re in cycle 1 -> rvalid=1 with rdata=0xA5 in cycle 2; count goes 0,1,0.
REQ-035 SHALL test: LOG2_DEPTH=5, write 31 words 0..30 -> count=31 and almostfull=1 from count 27; a 32nd write of 0xFF is dropped; 31 reads return 0..30 in order, then empty=1.
REQ-036 SHALL test: re=1 while empty -> rvalid=0, count=0; with BRAM_FIFO_ERROR_FLAGS_EN, underflow=1 next cycle and it persists.
REQ-037 SHALL test: 10 entries stored, then we=1 and re=1 every cycle for 100 cycles -> count stays 10, data in order across pointer wrap.
REQ-038 SHALL test: 5 entries stored, re issued, reset asserted the next cycle -> rvalid=0, empty=1, count=0 after reset; a fresh write of 0x3C reads back 0x3C.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for the BRAM-backed FIFO.
// The optional BRAM_FIFO_ERROR_FLAGS_EN build adds the overflow/underflow outputs.
package bram_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32;
    localparam int unsigned DEFAULT_LOG2_DEPTH = 5;
    localparam int unsigned DEFAULT_AF_MARGIN  = 4;

    // One slot is kept free, so usable capacity is one less than the BRAM depth.
    function automatic int unsigned fifo_cap(input int unsigned log2_depth);
        return (32'd1 << log2_depth) - 32'd1;
    endfunction

    // Saturates at zero so an oversized margin keeps almostfull asserted.
    function automatic int unsigned af_threshold(input int unsigned log2_depth,
                                                 input int unsigned margin);
        int unsigned cap;
        cap = fifo_cap(log2_depth);
        return (cap > margin) ? (cap - margin) : 32'd0;
    endfunction

endpackage

// File: rtl/simple_dual_port_bram.sv
// Simple dual-port block RAM: one write port and one registered read port
// with one cycle of latency. The read register resets to zero and holds when idle.
module simple_dual_port_bram #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bram_fifo.sv
// Synchronous FIFO on a simple dual-port BRAM with registered count and flags.
// Define BRAM_FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow outputs.
module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH             = DEFAULT_WIDTH,
    parameter int unsigned LOG2_DEPTH        = DEFAULT_LOG2_DEPTH,
    parameter int unsigned ALMOSTFULL_MARGIN = DEFAULT_AF_MARGIN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  almostfull,
    output logic                  empty,
    output logic [LOG2_DEPTH-1:0] count
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [LOG2_DEPTH-1:0] CAP       = '1;
    localparam logic [LOG2_DEPTH-1:0] ONE       = 1;
    localparam int unsigned           AF_THRESH = af_threshold(LOG2_DEPTH, ALMOSTFULL_MARGIN);

    logic [LOG2_DEPTH-1:0] wptr;
    logic [LOG2_DEPTH-1:0] rptr;
    logic [LOG2_DEPTH-1:0] count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // Read acceptance uses the registered empty, so a write into an empty FIFO
    // never bypasses to the read side in the same cycle.
    assign wr_acc = we && (count != CAP) && !reset;
    assign rd_acc = re && !empty && !reset;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + ONE;
        end else if (rd_acc && !wr_acc) begin
            count_next = count - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            empty      <= 1'b1;
            almostfull <= 1'b0;
            rvalid     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + ONE;
            end
            count      <= count_next;
            empty      <= (count_next == '0);
            almostfull <= (32'(count_next) >= AF_THRESH);
            rvalid     <= rd_acc;
        end
    end

`ifdef BRAM_FIFO_ERROR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we && (count == CAP)) begin
                overflow <= 1'b1;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    simple_dual_port_bram #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (LOG2_DEPTH)
    ) u_bram (
        .clk   (clk),
        .reset (reset),
        .wen   (wr_acc),
        .waddr (wptr),
        .wdata (wdata),
        .ren   (rd_acc),
        .raddr (rptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_bram_fifo.sv
// Self-checking bench for bram_fifo: a vector table plus scoreboarded sequences.
// Overflow/underflow checks compile in with BRAM_FIFO_ERROR_FLAGS_EN.
module tb_bram_fifo;

    localparam int WIDTH     = 32;
    localparam int LOG2_D    = 5;
    localparam int CAP       = 31;
    localparam int AF_THRESH = 27;

    logic              clk = 1'b0;
    logic              reset;
    logic              we;
    logic [WIDTH-1:0]  wdata;
    logic              re;
    logic [WIDTH-1:0]  rdata;
    logic              rvalid;
    logic              almostfull;
    logic              empty;
    logic [LOG2_D-1:0] count;
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_q   [$];
    logic [WIDTH-1:0] last_rdata;

    typedef struct {
        logic        we;
        logic [31:0] wdata;
        logic        re;
        int          exp_count;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    bram_fifo #(
        .WIDTH             (WIDTH),
        .LOG2_DEPTH        (LOG2_D),
        .ALMOSTFULL_MARGIN (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wdata      (wdata),
        .re         (re),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .almostfull (almostfull),
        .empty      (empty),
        .count      (count)
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: model acceptance from the bench's own occupancy, then check after the edge.
    task automatic step(input logic w, input logic [31:0] d, input logic r);
        logic racc;
        logic wacc;
        wacc = w && (model_q.size() < CAP);
        racc = r && (model_q.size() > 0);
        if (racc) exp_q.push_back(model_q.pop_front());
        if (wacc) model_q.push_back(d);
        we    = w;
        wdata = d;
        re    = r;
        @(posedge clk);
        #1;
        chk("rvalid", 32'(rvalid), 32'(racc));
        if (racc) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underrun", 32'd1, 32'd0);
            end else begin
                last_rdata = exp_q.pop_front();
            end
        end
        chk("rdata", rdata, last_rdata);
        chk("count", 32'(count), 32'(model_q.size()));
        chk("empty", 32'(empty), 32'(model_q.size() == 0));
        chk("almostfull", 32'(almostfull), 32'(model_q.size() >= AF_THRESH));
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic do_reset(input logic w, input logic r);
        reset = 1'b1;
        we    = w;
        re    = r;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        model_q.delete();
        exp_q.delete();
        last_rdata = '0;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_almostfull", 32'(almostfull), 32'd0);
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
`endif
    endtask

    initial begin
        reset      = 1'b1;
        we         = 1'b0;
        re         = 1'b0;
        wdata      = '0;
        last_rdata = '0;

        vecs[0] = '{1'b1, 32'hA5, 1'b0, 1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0,  1'b1, 0, 1'b1, 32'hA5};
        vecs[2] = '{1'b0, 32'h0,  1'b0, 0, 1'b0, 32'hA5};
        vecs[3] = '{1'b0, 32'h0,  1'b1, 0, 1'b0, 32'hA5};
        vecs[4] = '{1'b1, 32'h5A, 1'b1, 1, 1'b0, 32'hA5};
        vecs[5] = '{1'b1, 32'hC3, 1'b1, 1, 1'b1, 32'h5A};
        vecs[6] = '{1'b0, 32'h0,  1'b1, 0, 1'b1, 32'hC3};
        vecs[7] = '{1'b0, 32'h0,  1'b0, 0, 1'b0, 32'hC3};

        repeat (2) @(posedge clk);
        do_reset(1'b1, 1'b1);

        // Single word round trip, empty read, write-only on empty, simultaneous ops.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].we, vecs[i].wdata, vecs[i].re);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].exp_rvalid));
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
        chk("underflow_sticky", 32'(underflow), 32'd1);
        chk("overflow_clear", 32'(overflow), 32'd0);
`endif

        // Fill to capacity, drop one write, drain in order.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < CAP; i++) step(1'b1, 32'(i), 1'b0);
        chk("full_count", 32'(count), 32'd31);
        chk("full_af", 32'(almostfull), 32'd1);
        step(1'b1, 32'hFF, 1'b0);
        chk("drop_count", 32'(count), 32'd31);
`ifdef BRAM_FIFO_ERROR_FLAGS_EN
        chk("overflow_set", 32'(overflow), 32'd1);
`endif
        for (int i = 0; i < CAP; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk($sformatf("drain%0d", i), rdata, 32'(i));
        end
        chk("drained_empty", 32'(empty), 32'd1);

        // Steady-state streaming across pointer wrap.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h1000 + 32'(i), 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 32'h2000 + 32'(i), 1'b1);
            chk("stream_count", 32'(count), 32'd10);
        end

        // Reset while a read is in flight.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h50 + 32'(i), 1'b0);
        step(1'b0, 32'h0, 1'b1);
        do_reset(1'b1, 1'b1);
        step(1'b1, 32'h3C, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk("post_reset_data", rdata, 32'h3C);
        chk("post_reset_valid", 32'(rvalid), 32'd1);
        step(1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
